// File: rtl/nco_output_assembler_if.sv
// Sample-bus bundle between the NCO core serialiser and the output assembler.
// master drives the load request and the beat bus; slave returns the assembled results.
interface nco_output_assembler_if #(
    parameter int DATA_W = 12,
    parameter int PIN_W  = 2,
    parameter int NUM_CH = 2
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                    start;
    logic [NUM_CH*PIN_W-1:0] din;
    logic                    neg_in;
    logic                    sat_en;
    logic                    sel_fmt;
    logic [CH_W-1:0]         sel_ch;
    logic [DATA_W-1:0]       dout;
    logic                    dout_vld;
    logic                    busy;
    logic [NUM_CH-1:0]       ovf;

    modport master (
        output start, din, neg_in, sat_en, sel_fmt, sel_ch,
        input  dout, dout_vld, busy, ovf
    );

    modport slave (
        input  start, din, neg_in, sat_en, sel_fmt, sel_ch,
        output dout, dout_vld, busy, ovf
    );
endinterface

// File: rtl/nco_output_assembler.sv
// Rebuilds per-channel samples from a narrow pin bus (LSB chunk first), then applies
// optional negation/saturation and offset-binary formatting before a registered output.
module nco_output_assembler #(
    parameter int DATA_W = 12,
    parameter int PIN_W  = 2,
    parameter int NUM_CH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    nco_output_assembler_if.slave bus
);
    localparam int BEATS = DATA_W / PIN_W;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [DATA_W-1:0] MSB_MASK = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, LOAD, CALC} state_t;

    state_t                   state, state_nxt;
    logic [CNT_W-1:0]         cnt, cnt_nxt;
    logic                     load_en, last_beat, calc_en;

    logic signed [DATA_W-1:0] asm_p0 [NUM_CH];
    logic                     neg_p0, sat_p0, fmt_p0;

    logic signed [DATA_W-1:0] res_nxt [NUM_CH];
    logic [NUM_CH-1:0]        ovf_nxt;
    logic [DATA_W-1:0]        res_p1 [NUM_CH];
    logic [NUM_CH-1:0]        ovf_p1;
    logic                     vld_p1;
    logic [DATA_W-1:0]        dout_mux;

    // Returns {overflow, result}; only the most-negative input can overflow on negation.
    function automatic logic [DATA_W:0] negate_sat(
        input logic signed [DATA_W-1:0] x,
        input logic                     neg,
        input logic                     sat
    );
        logic signed [DATA_W-1:0] r;
        logic                     o;
        o = neg && (x == $signed(MSB_MASK));
        r = neg ? -x : x;
        if (o && sat)
            r = $signed(~MSB_MASK);
        return {o, r};
    endfunction

    function automatic logic [DATA_W-1:0] to_format(
        input logic [DATA_W-1:0] r,
        input logic              fmt
    );
        return fmt ? (r ^ MSB_MASK) : r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load_en   = 1'b0;
        last_beat = 1'b0;
        calc_en   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = LOAD;
                    cnt_nxt   = '0;
                end
            end
            LOAD: begin
                load_en = 1'b1;
                if (cnt == LAST_BEAT) begin
                    last_beat = 1'b1;
                    state_nxt = CALC;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            CALC: begin
                calc_en   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: beat assembly and control capture on the final beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++)
                asm_p0[c] <= '0;
            neg_p0 <= 1'b0;
            sat_p0 <= 1'b0;
            fmt_p0 <= 1'b0;
        end else if (load_en) begin
            for (int c = 0; c < NUM_CH; c++)
                asm_p0[c][int'(cnt)*PIN_W +: PIN_W] <= bus.din[c*PIN_W +: PIN_W];
            if (last_beat) begin
                neg_p0 <= bus.neg_in;
                sat_p0 <= bus.sat_en;
                fmt_p0 <= bus.sel_fmt;
            end
        end
    end

    always_comb begin
        ovf_nxt = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            {ovf_nxt[c], res_nxt[c]} = negate_sat(asm_p0[c], neg_p0, sat_p0);
        end
    end

    // Stage p1: registered results, overflow flags and valid strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++)
                res_p1[c] <= '0;
            ovf_p1 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= calc_en;
            if (calc_en) begin
                for (int c = 0; c < NUM_CH; c++)
                    res_p1[c] <= to_format(res_nxt[c], fmt_p0);
                ovf_p1 <= ovf_nxt;
            end
        end
    end

    // Unregistered channel select; out-of-range selects read as zero
    always_comb begin
        dout_mux = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (bus.sel_ch == CH_W'(c))
                dout_mux = res_p1[c];
        end
    end

    assign bus.dout     = dout_mux;
    assign bus.dout_vld = vld_p1;
    assign bus.busy     = (state != IDLE);
    assign bus.ovf      = ovf_p1;
endmodule

// File: doc/nco_output_assembler.md
# nco_output_assembler

Parametrised output assembler for the NCO pad ring. It gathers each channel's sample from a narrow pin bus, PIN_W bits per beat, and rebuilds a DATA_W-bit word. It then applies optional negation with optional saturation and an optional offset-binary conversion, and presents one selected channel on a registered output with a valid strobe. It sits between the NCO core's serialised sample bus and the chip output pins.

## Interface
- DATA_W, 12, sample width; must be an integer multiple of PIN_W.
- PIN_W, 2, bits per channel per beat.
- NUM_CH, 2, number of channels assembled in parallel; must be ≥ 1.
- BEATS (localparam) = DATA_W/PIN_W.
- CH_W (localparam) = max(1, clog2(NUM_CH)).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request to load one sample set; honoured in IDLE only.
- din  in  NUM_CH*PIN_W  beat bus; channel c occupies bits [c*PIN_W +: PIN_W].
- neg_in  in  1  negate request; sampled on the last load beat.
- sat_en  in  1  saturate on negation overflow; sampled on the last load beat.
- sel_fmt  in  1  1 = offset binary (MSB inverted), 0 = two's complement; sampled on the last load beat.
- sel_ch  in  CH_W  output channel select; combinational.
- dout  out  DATA_W  processed sample of channel sel_ch.
- dout_vld  out  1  one-cycle pulse when new results are registered.
- busy  out  1  high in the LOAD and CALC states.
- ovf  out  NUM_CH  per-channel flag: negation of the most-negative value; registered with results.

## Operation
- The FSM has three states: IDLE, LOAD and CALC. Reset enters IDLE.
- IDLE → LOAD when start=1. start is ignored in LOAD and CALC, with no queueing.
- LOAD lasts exactly BEATS cycles; a beat counter runs from 0 to BEATS-1.
  - Beat b writes din chunk c into shift/assembly bits [b*PIN_W +: PIN_W] of channel c.
  - Beats are delivered LSB chunk first.
- On beat BEATS-1, neg_in, sat_en and sel_fmt are captured into control registers. The FSM then moves LOAD → CALC.
- CALC takes one cycle. For each channel x:
  - If neg=0: r = x.
  - If neg=1: r = (~x + 1) mod 2^DATA_W.
  - If neg=1 and x = 1<<(DATA_W-1), ovf[c]=1. In that case r = 2^(DATA_W-1)-1 when sat=1; r stays 1<<(DATA_W-1) when sat=0.
  - If fmt=1: r[DATA_W-1] is inverted, i.e. +2^(DATA_W-1) mod 2^DATA_W. This is applied after saturation.
  - r and ovf are registered into per-channel result registers.
  - dout_vld pulses. CALC → IDLE.
- dout = result[sel_ch]. If sel_ch ≥ NUM_CH, dout = 0.
- Result registers hold their value until the next CALC.
- All arithmetic is modulo 2^DATA_W with no width growth. ovf reflects only the most recent set.

## Timing
- Reset values: state IDLE, dout 0, dout_vld 0, busy 0, ovf 0, all assembly, control and result registers 0.
- start is high at edge k:
  - din beats are sampled at edges k+1 … k+BEATS.
  - Results, ovf and dout_vld=1 are registered at edge k+BEATS+1.
  - dout_vld returns to 0 at edge k+BEATS+2.
- busy is high from edge k+1 through edge k+BEATS+1, and low after that edge.
- Minimum start-to-start period is BEATS+2 cycles. A start asserted in the cycle where dout_vld=1 is accepted.
- A change in sel_ch is reflected on dout in the same cycle; no register sits in that path.
- Reset mid-LOAD or mid-CALC: the partial sample is discarded, no dout_vld is issued, and all registers return to reset values.
- Holding start high continuously restarts a load every BEATS+2 cycles.

## Test plan
- Reset then plain load (DATA_W=12, PIN_W=2, NUM_CH=2; neg=0, fmt=0):
  - Stimulus: ch0 beats 3,0,2,0,1,0 and ch1 beats 0,3,3,2,2,2.
  - Required response: dout_vld pulses at k+7; sel_ch=0 gives 0x123, sel_ch=1 gives 0xABC; ovf=00.
- Negate and format on the same 0x123/0xABC data:
  - neg=1, fmt=0 → 0xEDD / 0x544.
  - neg=1, fmt=1 → 0x6DD / 0xD44.
  - neg=0, fmt=1 → 0x923 / 0x2BC.
- Overflow: ch0=0x800, ch1=0x001, neg=1.
  - sat_en=1 → 0x7FF / 0xFFF, ovf=01.
  - sat_en=0 → 0x800 / 0xFFF, ovf=01.
- Handshake:
  - A second start asserted during beats 2 and CALC is ignored; exactly one dout_vld is produced.
  - start asserted in the dout_vld cycle is accepted, giving a period of 8 cycles.
  - Held start yields dout_vld every 8 cycles.
- Reset mid-LOAD after beat 3: dout=0, busy=0, and no dout_vld appears. A following clean load of 0x123 returns 0x123.
- Parameter sweep with DATA_W=16, PIN_W=4, NUM_CH=3:
  - ch2 beats 0xF,0xF,0xF,0x7 → 0x7FFF.
  - neg=1 → 0x8001.
  - sel_ch=3 → dout=0.
